// File: rtl/temporal_encoder_pkg.sv
// Shared constants for the temporal encoder: default dimensions, FSM encodings
// and the fill-counter sizing helper.
package temporal_encoder_pkg;

    localparam int HV_DIMENSION_DEF = 2000;
    localparam int NGRAM_SIZE_DEF   = 3;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter must hold NGRAM_SIZE-1; never narrower than one bit.
    function automatic int fill_cnt_width(input int ngram_size);
        int w;
        w = $clog2(ngram_size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/temporal_encoder_hv_rotate.sv
// Combinational cyclic rotation of a hypervector by SHIFT positions toward
// higher bit index: out[i] = in[(i - SHIFT) mod HV_DIMENSION].
module hv_rotate #(
    parameter int HV_DIMENSION = 8,
    parameter int SHIFT        = 1
) (
    input  logic [0:HV_DIMENSION-1] Vector_DI,
    output logic [0:HV_DIMENSION-1] Vector_DO
);

    localparam int S = SHIFT % HV_DIMENSION;

    for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_bit
        assign Vector_DO[i] = Vector_DI[(i + HV_DIMENSION - S) % HV_DIMENSION];
    end

endmodule

// File: rtl/temporal_encoder.sv
// N-gram temporal encoder: keeps the last NGRAM_SIZE-1 accepted hypervectors and
// emits input ^ rho(H0) ^ rho^2(H1) ^ ... once the history is full.
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    Flush_SI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] NgramOut_DO
);

    localparam int HIST_LEN = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam int CW       = fill_cnt_width(NGRAM_SIZE);
    localparam logic [CW-1:0] FILL_MAX  = CW'((NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 0);
    localparam logic [CW-1:0] FILL_LAST = CW'((NGRAM_SIZE > 1) ? NGRAM_SIZE - 2 : 0);
    // Unigrams have nothing to fill, so they live permanently in RUN.
    localparam logic [0:0]    ST_INIT   = (NGRAM_SIZE > 1) ? ST_FILL : ST_RUN;

    logic [0:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [0:HV_DIMENSION-1] ngram_q, ngram_d;
    logic [0:HV_DIMENSION-1] hist_q [HIST_LEN];
    logic [0:HV_DIMENSION-1] hist_d [HIST_LEN];
    logic [0:HV_DIMENSION-1] acc_w  [NGRAM_SIZE];
    logic                    accept;

    // Stage k folds rho^k(H[k-1]) into the running XOR of the input.
    assign acc_w[0] = HypervectorIn_DI;
    for (genvar k = 1; k < NGRAM_SIZE; k++) begin : g_tap
        logic [0:HV_DIMENSION-1] rot_w;
        hv_rotate #(
            .HV_DIMENSION(HV_DIMENSION),
            .SHIFT       (k)
        ) u_rot (
            .Vector_DI(hist_q[k-1]),
            .Vector_DO(rot_w)
        );
        assign acc_w[k] = acc_w[k-1] ^ rot_w;
    end

    assign ReadyOut_SO = !Flush_SI && (!valid_q || ReadyIn_SI);
    assign accept      = ValidIn_SI && ReadyOut_SO;
    assign ValidOut_SO = valid_q;
    assign NgramOut_DO = ngram_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ngram_d = ngram_q;
        hist_d  = hist_q;
        if (Flush_SI) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            valid_d = 1'b0;
            for (int k = 0; k < HIST_LEN; k++) hist_d[k] = '0;
        end else begin
            if (valid_q && ReadyIn_SI) valid_d = 1'b0;
            if (accept) begin
                hist_d[0] = HypervectorIn_DI;
                for (int k = 1; k < HIST_LEN; k++) hist_d[k] = hist_q[k-1];
                if (state_q == ST_RUN) begin
                    ngram_d = acc_w[NGRAM_SIZE-1];
                    valid_d = 1'b1;
                end else if (cnt_q != FILL_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == FILL_LAST) state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ngram_q <= '0;
            for (int k = 0; k < HIST_LEN; k++) hist_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ngram_q <= ngram_d;
            for (int k = 0; k < HIST_LEN; k++) hist_q[k] <= hist_d[k];
        end
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder: a trigram instance driven from a vector
// table plus hand-written reset and unigram sequences.
module tb_temporal_encoder;

    localparam int D = 8;

    typedef struct packed {
        logic         valid_in;
        logic         flush;
        logic         ready_in;
        logic [D-1:0] data;
        logic         exp_ready;
        logic         exp_valid;
        logic [D-1:0] exp_data;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         flush = 1'b0, vin = 1'b0, rin = 1'b0;
    logic [0:D-1] din = '0;
    logic         rdy, vout;
    logic [0:D-1] dout;

    logic         flush1 = 1'b0, vin1 = 1'b0, rin1 = 1'b0;
    logic [0:D-1] din1 = '0;
    logic         rdy1, vout1;
    logic [0:D-1] dout1;

    int total = 0;
    int bad   = 0;

    vec_t vec [20];

    always #5 clk = ~clk;

    temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) dut (
        .Clk_CI(clk), .Reset_RBI(rst_n), .Flush_SI(flush),
        .ValidIn_SI(vin), .ReadyOut_SO(rdy), .HypervectorIn_DI(din),
        .ValidOut_SO(vout), .ReadyIn_SI(rin), .NgramOut_DO(dout)
    );

    temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI(clk), .Reset_RBI(rst_n), .Flush_SI(flush1),
        .ValidIn_SI(vin1), .ReadyOut_SO(rdy1), .HypervectorIn_DI(din1),
        .ValidOut_SO(vout1), .ReadyIn_SI(rin1), .NgramOut_DO(dout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus on the trigram instance, no checking.
    task automatic step(input logic v, input logic [D-1:0] d, input logic r);
        @(negedge clk);
        vin = v; din = d; rin = r; flush = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic r, input logic [D-1:0] d,
                                input logic er, input logic ev, input logic [D-1:0] ed);
        vec_t t;
        t.valid_in = v; t.flush = f; t.ready_in = r; t.data = d;
        t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed;
        return t;
    endfunction

    initial begin
        // basic stream, consume and accept in the same cycle, idle
        vec[0]  = mk(1, 0, 1, 8'h80, 1, 0, 8'h00);
        vec[1]  = mk(1, 0, 1, 8'h01, 1, 0, 8'h00);
        vec[2]  = mk(1, 0, 1, 8'h0F, 1, 1, 8'hAF);
        vec[3]  = mk(1, 0, 1, 8'h00, 1, 1, 8'hC7);
        vec[4]  = mk(0, 0, 1, 8'h00, 1, 0, 8'hC7);
        // flush with nothing pending, then the stream under backpressure
        vec[5]  = mk(1, 1, 1, 8'hFF, 0, 0, 8'hC7);
        vec[6]  = mk(1, 0, 0, 8'h80, 1, 0, 8'hC7);
        vec[7]  = mk(1, 0, 0, 8'h01, 1, 0, 8'hC7);
        vec[8]  = mk(1, 0, 0, 8'h0F, 1, 1, 8'hAF);
        vec[9]  = mk(1, 0, 0, 8'h00, 0, 1, 8'hAF);
        vec[10] = mk(1, 0, 0, 8'h00, 0, 1, 8'hAF);
        vec[11] = mk(1, 0, 0, 8'h00, 0, 1, 8'hAF);
        vec[12] = mk(1, 0, 1, 8'h00, 1, 1, 8'hC7);
        vec[13] = mk(0, 0, 1, 8'h00, 1, 0, 8'hC7);
        // history is now H0=00,H1=0F: FF ^ rho(00) ^ rho^2(0F) = FF ^ C3
        vec[14] = mk(1, 0, 1, 8'hFF, 1, 1, 8'h3C);
        // flush while an output is pending, then refill from scratch
        vec[15] = mk(1, 1, 0, 8'hAA, 0, 0, 8'h3C);
        vec[16] = mk(1, 0, 1, 8'h11, 1, 0, 8'h3C);
        vec[17] = mk(1, 0, 1, 8'h22, 1, 0, 8'h3C);
        vec[18] = mk(1, 0, 1, 8'h44, 1, 1, 8'h11);
        vec[19] = mk(0, 0, 1, 8'h00, 1, 0, 8'h11);

        // reset for two cycles
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_valid", 32'(vout), 32'd0);
        check("reset_data", 32'(dout), 32'h00);
        check("reset_ready", 32'(rdy), 32'd1);
        check("reset_valid_n1", 32'(vout1), 32'd0);
        check("reset_ready_n1", 32'(rdy1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vin = vec[i].valid_in; flush = vec[i].flush;
            rin = vec[i].ready_in; din = vec[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vec[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(vout), 32'(vec[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(dout), 32'(vec[i].exp_data));
        end

        // asynchronous reset in the middle of a pending output
        @(negedge clk);
        flush = 1'b1; vin = 1'b0;
        @(posedge clk);
        step(1, 8'h80, 0);
        step(1, 8'h01, 0);
        step(1, 8'h0F, 0);
        check("arst_pre_valid", 32'(vout), 32'd1);
        check("arst_pre_data", 32'(dout), 32'hAF);
        @(negedge clk);
        vin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_drop", 32'(vout), 32'd0);
        check("arst_data_clear", 32'(dout), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h80, 1);
        check("arst_refill1", 32'(vout), 32'd0);
        step(1, 8'h01, 1);
        check("arst_refill2", 32'(vout), 32'd0);
        step(1, 8'h0F, 1);
        check("arst_out_valid", 32'(vout), 32'd1);
        check("arst_out_data", 32'(dout), 32'hAF);
        step(0, 8'h00, 1);
        check("arst_out_done", 32'(vout), 32'd0);

        // unigram instance: output equals input, no fill phase
        @(negedge clk);
        vin1 = 1'b1; din1 = 8'h5A; rin1 = 1'b1;
        @(posedge clk);
        #1;
        check("n1_valid", 32'(vout1), 32'd1);
        check("n1_data", 32'(dout1), 32'h5A);
        @(negedge clk);
        din1 = 8'hA5;
        #1;
        check("n1_ready", 32'(rdy1), 32'd1);
        @(posedge clk);
        #1;
        check("n1_valid2", 32'(vout1), 32'd1);
        check("n1_data2", 32'(dout1), 32'hA5);
        @(negedge clk);
        vin1 = 1'b0;
        @(posedge clk);
        #1;
        check("n1_idle", 32'(vout1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Downstream neighbour of the spatial encoder. It consumes one spatial hypervector per accepted handshake and keeps the last NGRAM_SIZE-1 accepted vectors in a history buffer. For every accepted vector once the history is full, it emits the N-gram hypervector: the current input XOR the permuted history. Its output feeds the associative memory / class accumulator.

## Interface
Parameters:
- HV_DIMENSION, default `HV_DIMENSION (2000): hypervector width in bits, bit order [0:HV_DIMENSION-1].
- NGRAM_SIZE, default `NGRAM_SIZE (3): N-gram length. Legal range 1..8.

Ports:
- Clk_CI, input, 1: single clock; all state updates on the rising edge.
- Reset_RBI, input, 1: reset, asynchronous, active-low.
- Flush_SI, input, 1: synchronous history clear, used on window or label change.
- ValidIn_SI, input, 1: spatial hypervector valid (spatial encoder ValidOut).
- ReadyOut_SO, output, 1: block can accept an input (drives spatial encoder ReadyIn).
- HypervectorIn_DI, input, [0:HV_DIMENSION-1]: spatial hypervector.
- ValidOut_SO, output, 1: N-gram output valid.
- ReadyIn_SI, input, 1: downstream ready.
- NgramOut_DO, output, [0:HV_DIMENSION-1]: registered N-gram hypervector.

## Operation
- Accept condition: ValidIn_SI && ReadyOut_SO.
- ReadyOut_SO is combinational: !Flush_SI && (!ValidOut_SO || ReadyIn_SI).
- Permutation: rho(x)[i] = x[(i-1) mod HV_DIMENSION], a rotate by one toward higher index. rho^k applies rho k times.
- History buffer H[0..NGRAM_SIZE-2]. On accept:
  - H[0] <= in.
  - H[k] <= H[k-1].
- N-gram = in ^ rho(H[0]) ^ rho^2(H[1]) ^ ... ^ rho^(N-1)(H[N-2]).
- FSM:
  - FILL: FillCntr < NGRAM_SIZE-1. An accept shifts history and increments FillCntr; no output is produced. When FillCntr reaches NGRAM_SIZE-1, go to RUN.
  - RUN: an accept shifts history, loads NgramOut_DP with the N-gram computed from the pre-shift history, and sets ValidOut_SO.
- NGRAM_SIZE=1: no history, the FSM is always RUN, and output = input.
- Output register:
  - ValidOut_SO clears on ReadyIn_SI && ValidOut_SO unless a new N-gram is loaded in the same cycle.
  - Data holds stable while ValidOut_SO && !ReadyIn_SI.
- Flush_SI (priority over everything except reset), on the next edge:
  - history <= 0, FillCntr <= 0, state <= FILL, ValidOut_SO <= 0.
  - A pending output is discarded.
  - No input is accepted in a flush cycle.
- Reset values: state FILL, FillCntr 0, history all 0, ValidOut_SO 0, NgramOut_DO all 0. ReadyOut_SO = 1 after reset (Flush_SI low).

## Timing
- Latency: NgramOut_DO and ValidOut_SO are valid the cycle after the accepting edge.
- Throughput: one N-gram per cycle in RUN with ReadyIn_SI held high.
- Backpressure: ValidOut_SO && !ReadyIn_SI forces ReadyOut_SO low. History is frozen; no input is lost or duplicated.
- Simultaneous output consume and new accept: the new N-gram replaces the old one and ValidOut_SO stays 1.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Deassertion is synchronous to Clk_CI.
- FillCntr width: $clog2(NGRAM_SIZE) bits, minimum 1. It saturates at NGRAM_SIZE-1.

## Structure
- HV_DIMENSION and NGRAM_SIZE defaults come from const.vh, shared with the spatial encoder.
- FSM state encodings FILL and RUN are localparams.
- One sub-module: hv_rotate (combinational, parameters HV_DIMENSION and SHIFT), instantiated once per history tap with SHIFT=k.
- History and output registers live in temporal_encoder.

## Test plan
Use HV_DIMENSION=8 and NGRAM_SIZE=3 unless stated. Hex values are written MSB-first, with bit 0 as the MSB.
- Reset:
  - Stimulus: drive Reset_RBI=0 for 2 cycles, then release.
  - Required: ValidOut_SO=0, NgramOut_DO=8'h00, ReadyOut_SO=1, and no output for the first two accepts.
- Basic N-gram:
  - Stimulus: accept 8'h80, 8'h01, 8'h0F, then 8'h00 with ReadyIn_SI=1.
  - Required: outputs 8'hAF after the third accept and 8'hC7 after the fourth, one cycle each.
- Backpressure:
  - Stimulus: same stream with ReadyIn_SI=0 for 3 cycles after the first output.
  - Required: NgramOut_DO holds 8'hAF, ReadyOut_SO=0, and 8'h00 is not consumed until ReadyIn_SI rises, then 8'hC7 follows.
- Flush:
  - Stimulus: assert Flush_SI while ValidOut_SO=1.
  - Required: the output is dropped. The next two accepts produce nothing; the third produces the N-gram from the post-flush inputs only.
- Async reset mid-stream:
  - Stimulus: drop Reset_RBI between clock edges while in RUN.
  - Required: ValidOut_SO falls without waiting for a clock edge. Afterwards a full refill of 2 inputs is needed before any output.
- NGRAM_SIZE=1:
  - Stimulus: accept 8'h5A.
  - Required: output 8'h5A one cycle later, with no fill phase.
